alu_sweep_ctrl: RTL and testbench

- Sequencer placed in front of the combinational ALU (operand-preset select AB_SW, opcode ALU_OP).
- On a start request, latches an operand preset, then steps ALU_OP through the enabled opcodes in ascending order.
- For each opcode, waits a settle window, then captures the ALU result and flags into an 8-entry result buffer.
- Board logic or testbench reads results back by opcode index; busy/done handshake.

---
 rtl/alu_sweep_ctrl_if.sv | 31 +++
 rtl/alu_sweep_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sweep_ctrl_if.sv
// Bundle between the ALU sweep sequencer, the ALU under test and the board/bench
// readback logic. The slave modport is the sequencer's view.
interface alu_sweep_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        sw_sel;
  logic [7:0]        op_mask;
  logic [2:0]        AB_SW;
  logic [2:0]        ALU_OP;
  logic [DATA_W-1:0] alu_f;
  logic              alu_zf;
  logic              alu_of;
  logic              busy;
  logic              done;
  logic [2:0]        rd_idx;
  logic [DATA_W-1:0] rd_f;
  logic              rd_zf;
  logic              rd_of;
  logic              rd_valid;

  modport master (
    output start, sw_sel, op_mask, alu_f, alu_zf, alu_of, rd_idx,
    input  AB_SW, ALU_OP, busy, done, rd_f, rd_zf, rd_of, rd_valid
  );

  modport slave (
    input  start, sw_sel, op_mask, alu_f, alu_zf, alu_of, rd_idx,
    output AB_SW, ALU_OP, busy, done, rd_f, rd_zf, rd_of, rd_valid
  );
endinterface

// File: rtl/alu_sweep_ctrl.sv
// Steps the ALU opcode through an enabled mask, holds each code for a settle
// window, and captures result/flags per opcode into an 8-entry readback buffer.
module alu_sweep_ctrl #(
  parameter int DATA_W = 32,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  alu_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] W_SETTLE = 4'(SETTLE);

  state_t            r_state, w_state_next;
  logic [7:0]        r_mask, w_mask_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic [2:0]        r_ab_sw, w_ab_sw_next;
  logic [2:0]        r_alu_op, w_alu_op_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic [7:0]        r_valid, w_valid_next;
  logic              w_cap_en;
  logic [7:0]        w_above;
  logic [DATA_W-1:0] w_ent_f [8];
  logic [7:0]        w_ent_zf;
  logic [7:0]        w_ent_of;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  // Enabled opcodes strictly above the current one; empty means this is the last.
  assign w_above = r_mask & (8'hFE << r_alu_op);

  always_comb begin
    w_state_next  = r_state;
    w_mask_next   = r_mask;
    w_cnt_next    = r_cnt;
    w_ab_sw_next  = r_ab_sw;
    w_alu_op_next = r_alu_op;
    w_busy_next   = r_busy;
    w_done_next   = r_done;
    w_valid_next  = r_valid;
    w_cap_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_valid_next = '0;
          w_ab_sw_next = bus.sw_sel;
          if (bus.op_mask != 8'h00) begin
            w_mask_next   = bus.op_mask;
            w_alu_op_next = lowest_set(bus.op_mask);
            w_cnt_next    = W_SETTLE;
            w_busy_next   = 1'b1;
            w_state_next  = S_RUN;
          end else begin
            w_done_next  = 1'b1;
            w_state_next = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_cap_en     = 1'b1;
          w_valid_next = r_valid | (8'b1 << r_alu_op);
          if (w_above != 8'h00) begin
            w_alu_op_next = lowest_set(w_above);
            w_cnt_next    = W_SETTLE;
          end else begin
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_done_next  = 1'b0;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mask   <= '0;
      r_cnt    <= '0;
      r_ab_sw  <= '0;
      r_alu_op <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_mask   <= w_mask_next;
      r_cnt    <= w_cnt_next;
      r_ab_sw  <= w_ab_sw_next;
      r_alu_op <= w_alu_op_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      r_valid  <= w_valid_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_entry
      logic [DATA_W-1:0] r_f;
      logic              r_zf;
      logic              r_of;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_f  <= '0;
          r_zf <= 1'b0;
          r_of <= 1'b0;
        end else if (w_cap_en && (r_alu_op == 3'(gi))) begin
          r_f  <= bus.alu_f;
          r_zf <= bus.alu_zf;
          r_of <= bus.alu_of;
        end
      end

      assign w_ent_f[gi]  = r_f;
      assign w_ent_zf[gi] = r_zf;
      assign w_ent_of[gi] = r_of;
    end
  endgenerate

  assign bus.AB_SW    = r_ab_sw;
  assign bus.ALU_OP   = r_alu_op;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rd_f     = w_ent_f[bus.rd_idx];
  assign bus.rd_zf    = w_ent_zf[bus.rd_idx];
  assign bus.rd_of    = w_ent_of[bus.rd_idx];
  assign bus.rd_valid = r_valid[bus.rd_idx];
endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Directed bench for alu_sweep_ctrl: two instances (SETTLE=1 and SETTLE=0), per-cycle
// scoreboard of busy/done/ALU_OP/AB_SW, plus readback checks against a small ALU model.
module tb_alu_sweep_ctrl;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] op;
    logic [2:0] ab;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  obs_t sbq[$];
  logic [2:0] last_op [2];

  always #5 clk = ~clk;

  alu_sweep_ctrl_if #(.DATA_W(DATA_W)) if0 ();
  alu_sweep_ctrl_if #(.DATA_W(DATA_W)) if1 ();

  alu_sweep_ctrl #(.DATA_W(DATA_W), .SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  alu_sweep_ctrl #(.DATA_W(DATA_W), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // Reference ALU stand-in driven by the sequencer's opcode.
  assign if0.alu_f  = 32'hA000_0000 | {29'd0, if0.ALU_OP};
  assign if0.alu_zf = (if0.ALU_OP == 3'd3);
  assign if0.alu_of = (if0.ALU_OP == 3'd6);
  assign if1.alu_f  = 32'hA000_0000 | {29'd0, if1.ALU_OP};
  assign if1.alu_zf = (if1.ALU_OP == 3'd3);
  assign if1.alu_of = (if1.ALU_OP == 3'd6);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t observe(input int which);
    obs_t o;
    if (which == 1) begin
      o.busy = if1.busy; o.done = if1.done; o.op = if1.ALU_OP; o.ab = if1.AB_SW;
    end else begin
      o.busy = if0.busy; o.done = if0.done; o.op = if0.ALU_OP; o.ab = if0.AB_SW;
    end
    return o;
  endfunction

  task automatic drive(input int which, input logic s, input logic [2:0] sw, input logic [7:0] m);
    if (which == 1) begin
      if1.start = s; if1.sw_sel = sw; if1.op_mask = m;
    end else begin
      if0.start = s; if0.sw_sel = sw; if0.op_mask = m;
    end
  endtask

  task automatic set_rd(input int which, input logic [2:0] idx);
    if (which == 1) if1.rd_idx = idx;
    else            if0.rd_idx = idx;
  endtask

  // Expected per-cycle observations from the cycle after the accept edge up to DONE.
  task automatic push_sweep(input int which, input logic [2:0] ab, input logic [7:0] mask,
                            input int settle);
    obs_t e;
    for (int op = 0; op < 8; op++) begin
      if (mask[op]) begin
        for (int h = 0; h <= settle; h++) begin
          e.busy = 1'b1; e.done = 1'b0; e.op = 3'(op); e.ab = ab;
          sbq.push_back(e);
        end
        last_op[which] = 3'(op);
      end
    end
    e.busy = 1'b0; e.done = 1'b1; e.op = last_op[which]; e.ab = ab;
    sbq.push_back(e);
  endtask

  task automatic push_idle(input int which, input logic [2:0] ab, input int cycles);
    obs_t e;
    for (int c = 0; c < cycles; c++) begin
      e.busy = 1'b0; e.done = 1'b0; e.op = last_op[which]; e.ab = ab;
      sbq.push_back(e);
    end
  endtask

  task automatic check_cycle(input int which);
    obs_t o;
    obs_t e;
    chk("sbq_nonempty", 64'(sbq.size() != 0), 64'(1));
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      o = observe(which);
      chk("busy", 64'(o.busy), 64'(e.busy));
      chk("done", 64'(o.done), 64'(e.done));
      chk("alu_op", 64'(o.op), 64'(e.op));
      chk("ab_sw", 64'(o.ab), 64'(e.ab));
    end
  endtask

  task automatic run_sweep(input int which, input logic [2:0] sw, input logic [7:0] mask,
                           input int settle, input int pulse_k);
    int n;
    @(negedge clk);
    $display("sweep dut%0d sw_sel=%0d op_mask=%02h settle=%0d", which, sw, mask, settle);
    drive(which, 1'b1, sw, mask);
    push_sweep(which, sw, mask, settle);
    push_idle(which, sw, 1);
    n = sbq.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_cycle(which);
      if (k == 0)                drive(which, 1'b0, ~sw, 8'h00);
      else if (k == pulse_k)     drive(which, 1'b1, ~sw, 8'hFF);
      else if (k == pulse_k + 1) drive(which, 1'b0, sw, 8'h00);
    end
  endtask

  task automatic rb(input int which, input logic [2:0] idx, input logic ev);
    logic [DATA_W-1:0] f;
    logic zf;
    logic of;
    logic v;
    set_rd(which, idx);
    #1;
    if (which == 1) begin f = if1.rd_f; zf = if1.rd_zf; of = if1.rd_of; v = if1.rd_valid; end
    else            begin f = if0.rd_f; zf = if0.rd_zf; of = if0.rd_of; v = if0.rd_valid; end
    $display("readback dut%0d idx=%0d valid=%0b f=%08h zf=%0b of=%0b", which, idx, v, f, zf, of);
    chk("rd_valid", 64'(v), 64'(ev));
    if (ev) begin
      chk("rd_f", 64'(f), 64'(32'hA000_0000 | {29'd0, idx}));
      chk("rd_zf", 64'(zf), 64'(idx == 3'd3));
      chk("rd_of", 64'(of), 64'(idx == 3'd6));
    end
  endtask

  initial begin
    logic [7:0] exp_v;
    last_op[0] = 3'd0;
    last_op[1] = 3'd0;
    drive(0, 1'b0, 3'd0, 8'h00);
    drive(1, 1'b0, 3'd0, 8'h00);
    set_rd(0, 3'd0);
    set_rd(1, 3'd0);

    // Reset state.
    #2;
    for (int w = 0; w < 2; w++) begin
      chk("rst_busy", 64'(observe(w).busy), 64'(0));
      chk("rst_done", 64'(observe(w).done), 64'(0));
      chk("rst_alu_op", 64'(observe(w).op), 64'(0));
      chk("rst_ab_sw", 64'(observe(w).ab), 64'(0));
    end
    for (int i = 0; i < 8; i++) rb(1, 3'(i), 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Full sweep with a start pulse during RUN that must be ignored.
    run_sweep(1, 3'd2, 8'hFF, 1, 5);
    for (int i = 0; i < 8; i++) rb(1, 3'(i), 1'b1);

    // Sparse mask.
    run_sweep(1, 3'd5, 8'b1000_0101, 1, -1);
    exp_v = 8'b1000_0101;
    for (int i = 0; i < 8; i++) rb(1, 3'(i), exp_v[i]);

    // Empty mask: immediate DONE, no busy, everything invalid.
    run_sweep(1, 3'd7, 8'h00, 1, -1);
    for (int i = 0; i < 8; i++) rb(1, 3'(i), 1'b0);

    // SETTLE=0 instance.
    run_sweep(0, 3'd4, 8'h0F, 0, -1);
    exp_v = 8'h0F;
    for (int i = 0; i < 8; i++) rb(0, 3'(i), exp_v[i]);

    // Reset during the third opcode of a full sweep.
    @(negedge clk);
    $display("sweep dut1 sw_sel=6 op_mask=ff settle=1 (reset mid-sweep)");
    drive(1, 1'b1, 3'd6, 8'hFF);
    push_sweep(1, 3'd6, 8'hFF, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_cycle(1);
      if (k == 0) drive(1, 1'b0, 3'd0, 8'h00);
    end
    set_rd(1, 3'd0);
    #1;
    chk("pre_rst_valid0", 64'(if1.rd_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(if1.busy), 64'(0));
    chk("midrst_done", 64'(if1.done), 64'(0));
    chk("midrst_alu_op", 64'(if1.ALU_OP), 64'(0));
    chk("midrst_ab_sw", 64'(if1.AB_SW), 64'(0));
    for (int i = 0; i < 8; i++) rb(1, 3'(i), 1'b0);
    sbq.delete();
    last_op[0] = 3'd0;
    last_op[1] = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    push_idle(1, 3'd0, 20);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_cycle(1);
    end
    run_sweep(1, 3'd1, 8'hFF, 1, -1);
    for (int i = 0; i < 8; i++) rb(1, 3'(i), 1'b1);

    // Back-to-back: start held high, second sweep accepted on the IDLE cycle after DONE.
    @(negedge clk);
    $display("sweep dut1 sw_sel=3 op_mask=03 then sw_sel=4 op_mask=40 (start held)");
    set_rd(1, 3'd0);
    drive(1, 1'b1, 3'd3, 8'h03);
    push_sweep(1, 3'd3, 8'h03, 1);
    push_idle(1, 3'd3, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_cycle(1);
      if (k == 5) begin
        chk("b2b_prev_valid", 64'(if1.rd_valid), 64'(1));
        drive(1, 1'b1, 3'd4, 8'h40);
      end
    end
    push_sweep(1, 3'd4, 8'h40, 1);
    push_idle(1, 3'd4, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_cycle(1);
      if (k == 0) begin
        chk("b2b_clear_valid", 64'(if1.rd_valid), 64'(0));
        drive(1, 1'b0, 3'd4, 8'h00);
      end
    end
    exp_v = 8'h40;
    for (int i = 0; i < 8; i++) rb(1, 3'(i), exp_v[i]);

    chk("sbq_drained", 64'(sbq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
